// File: rtl/imem_responder_if.sv
// imem_responder_if -- fetch-side handshake between the fetch stage and the
// instruction-memory responder.
//   proc2Imem_req   fetch request strobe (fetch stage -> memory)
//   proc2Imem_addr  fetch byte address, bits [1:0] ignored
//   Imem2proc_busy  request outstanding, initiator holds req/addr
//   Imem2proc_valid one-cycle response strobe
//   Imem2proc_data  returned instruction word
//   Imem2proc_err   qualifies valid: address was out of range
// Modports: master = fetch stage, slave = memory responder.
interface imem_responder_if;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic        Imem2proc_busy;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic        Imem2proc_err;

  modport master (
    output proc2Imem_req,
    output proc2Imem_addr,
    input  Imem2proc_busy,
    input  Imem2proc_valid,
    input  Imem2proc_data,
    input  Imem2proc_err
  );

  modport slave (
    input  proc2Imem_req,
    input  proc2Imem_addr,
    output Imem2proc_busy,
    output Imem2proc_valid,
    output Imem2proc_data,
    output Imem2proc_err
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder -- far end of the instruction-fetch interface.
// Accepts word-aligned fetch requests and returns the addressed instruction
// word a fixed LATENCY cycles after the accept edge with a one-cycle valid
// strobe. Holds the instruction array and a loader write port used to
// preload the program.
//
// Parameters:
//   DEPTH     number of 32-bit words in the array (power of 2, >= 4)
//   LATENCY   accept-edge to response-valid distance in cycles (1..15)
//   OOR_DATA  word returned for out-of-range fetch addresses
// Ports:
//   clk, rst  clock; asynchronous active-high reset
//   fetch     imem_responder_if.slave (req/addr in, busy/valid/data/err out)
//   load_en   loader write strobe
//   load_addr loader byte address, bits [1:0] ignored
//   load_data loader write word
//   stat_req_cnt, stat_busy_cyc  (only with IMEM_STATS_EN defined)
//             saturating counts of accepted requests and busy cycles
//
// Build option: define IMEM_STATS_EN to add the statistics counters/ports.
module imem_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] OOR_DATA = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  imem_responder_if.slave        fetch,
  input  logic                   load_en,
  input  logic [31:0]            load_addr,
  input  logic [31:0]            load_data
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0]            stat_req_cnt,
  output logic [31:0]            stat_busy_cyc
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [29:0] idx_q;
  logic [29:0] req_idx;
  logic [29:0] rd_idx;
  logic [29:0] ld_idx;
  logic        accept;
  logic        capture;
  logic        rd_in_range;
  logic        ld_in_range;
  logic [31:0] data_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  // Byte-offset bits are architecturally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch.proc2Imem_addr[1:0], load_addr[1:0]};

  assign req_idx = fetch.proc2Imem_addr[31:2];
  assign ld_idx  = load_addr[31:2];

  // Requests are only taken when nothing is waiting; a request seen in
  // RESP is the back-to-back case.
  assign accept = fetch.proc2Imem_req && ((state == IDLE) || (state == RESP));

  // Entering RESP straight from an accept only happens with LATENCY == 1,
  // in which case the live request index is read; otherwise the index
  // captured at accept time is used.
  assign rd_idx      = (state == WAIT) ? idx_q : req_idx;
  assign rd_in_range = {2'b00, rd_idx} < DEPTH_W;
  assign ld_in_range = {2'b00, ld_idx} < DEPTH_W;
  assign capture     = (state_n == RESP);

  // Next-state and counter logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE, RESP: begin
        if (accept) begin
          cnt_n   = CNT_INIT;
          state_n = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = RESP;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        idx_q <= req_idx;
      end
    end
  end

  // Response registers. err only ever lives for the RESP cycle it was
  // captured for; data is left holding after valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (capture) begin
      if (rd_in_range) begin
        data_q <= mem[rd_idx[AW-1:0]];
        err_q  <= 1'b0;
      end else begin
        data_q <= OOR_DATA;
        err_q  <= 1'b1;
      end
    end else begin
      err_q <= 1'b0;
    end
  end

  // Instruction array: never reset. Non-blocking update gives the
  // read-before-write ordering against a same-edge response capture.
  always_ff @(posedge clk) begin
    if (load_en && ld_in_range) begin
      mem[ld_idx[AW-1:0]] <= load_data;
    end
  end

  assign fetch.Imem2proc_busy  = (state == WAIT);
  assign fetch.Imem2proc_valid = (state == RESP);
  assign fetch.Imem2proc_data  = data_q;
  assign fetch.Imem2proc_err   = err_q;

`ifdef IMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_req_cnt  <= '0;
      stat_busy_cyc <= '0;
    end else begin
      if (accept && (stat_req_cnt != '1)) begin
        stat_req_cnt <= stat_req_cnt + 32'd1;
      end
      if ((state == WAIT) && (stat_busy_cyc != '1)) begin
        stat_busy_cyc <= stat_busy_cyc + 32'd1;
      end
    end
  end
`endif

endmodule
